// File: rtl/data_memory_responder.sv
// Data-memory responder: accepts one load/store at a time over valid/ready,
// waits LATENCY cycles in BUSY, then holds a response until it is taken.
// Little-endian RV64 byte/half/word/double accesses with sign/zero extension.
module data_memory_responder #(
  parameter int WORDSIZE = 64,
  parameter int DEPTH    = 512,
  parameter int LATENCY  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [WORDSIZE-1:0] req_addr,
  input  logic [2:0]          req_funct3,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WORDSIZE-1:0] resp_rdata,
  output logic                resp_error
);

  localparam int NUM_LANES = WORDSIZE / 8;
  localparam int IW        = $clog2(DEPTH);
  localparam int CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic                write;
    logic [2:0]          funct3;
    logic [WORDSIZE-1:0] addr;
    logic [WORDSIZE-1:0] wdata;
  } req_t;

  state_t              state, state_nxt;
  req_t                req_q;
  logic [CW-1:0]       cnt;
  logic                accept, access;
  logic [WORDSIZE-1:0] mem [DEPTH];

  logic [IW-1:0]       idx;
  logic [2:0]          off;
  logic [1:0]          size;
  logic                misalign, range_err, illegal, fault;
  logic [WORDSIZE-1:0] rd_word, rd_shift, ld_data, wr_shift;
  logic                sgn;
  logic [NUM_LANES-1:0]      size_mask, wr_be;
  logic [NUM_LANES-1:0][7:0] old_b, new_b, mrg_b;

  assign idx    = req_q.addr[3 +: IW];
  assign off    = req_q.addr[2:0];
  assign size   = req_q.funct3[1:0];
  assign sgn    = ~req_q.funct3[2];
  assign access = (state == BUSY) && (cnt == '0);

  // Fault classification of the captured request
  always_comb begin
    misalign = 1'b0;
    case (size)
      2'd1:    misalign = off[0];
      2'd2:    misalign = |off[1:0];
      2'd3:    misalign = |off;
      default: misalign = 1'b0;
    endcase
    range_err = |req_q.addr[WORDSIZE-1:3+IW];
    illegal   = req_q.write ? req_q.funct3[2] : (req_q.funct3 == 3'b111);
    fault     = misalign | range_err | illegal;
  end

  // Load path: align addressed bytes to bit 0, then extend by size/signedness
  always_comb begin
    rd_word  = mem[idx];
    rd_shift = rd_word >> {off, 3'b000};
    ld_data  = '0;
    case (size)
      2'd0:    ld_data = {{(WORDSIZE-8){sgn & rd_shift[7]}},   rd_shift[7:0]};
      2'd1:    ld_data = {{(WORDSIZE-16){sgn & rd_shift[15]}}, rd_shift[15:0]};
      2'd2:    ld_data = {{(WORDSIZE-32){sgn & rd_shift[31]}}, rd_shift[31:0]};
      default: ld_data = rd_shift;
    endcase
  end

  // Store path: byte enables and data placed at the byte offset
  always_comb begin
    case (size)
      2'd0:    size_mask = NUM_LANES'(8'h01);
      2'd1:    size_mask = NUM_LANES'(8'h03);
      2'd2:    size_mask = NUM_LANES'(8'h0F);
      default: size_mask = NUM_LANES'(8'hFF);
    endcase
    wr_be    = size_mask << off;
    wr_shift = req_q.wdata << {off, 3'b000};
  end

  assign old_b = rd_word;
  assign new_b = wr_shift;

  // Per-lane merge: enabled lanes take new data, the rest keep the old word
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign mrg_b[g] = wr_be[g] ? new_b[g] : old_b[g];
  end

  // Memory array (not reset); written only by a non-faulting store at access time
  always_ff @(posedge clk) begin
    if (access && req_q.write && !fault) mem[idx] <= mrg_b;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; req_ready is gated low during reset
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid && rst_n) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: if (cnt == '0) state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, latency counter and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      if (accept) begin
        req_q <= '{write: req_write, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
        cnt   <= CW'(LATENCY - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (access) begin
        resp_error <= fault;
        resp_rdata <= (fault || req_q.write) ? '0 : ld_data;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: two responders (LATENCY 2 and 1) share stimulus; sel picks
// which one is driven and observed. Expected responses are queued at issue
// and popped by a monitor at each response handshake.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_write, resp_ready, sel;
  logic [63:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rdy0, rdy1, rv0, rv1, err0, err1;
  logic [63:0] rd0, rd1;
  logic        rdy_m, rv_m, err_m;
  logic [63:0] rd_m;

  int          n_chk = 0, n_pass = 0, cyc = 0;
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  int          acc_t[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rdy_m = sel ? rdy1 : rdy0;
  assign rv_m  = sel ? rv1  : rv0;
  assign err_m = sel ? err1 : err0;
  assign rd_m  = sel ? rd1  : rd0;

  data_memory_responder #(.WORDSIZE(64), .DEPTH(512), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rdy0),
    .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3),
    .req_wdata(req_wdata), .resp_valid(rv0), .resp_ready(resp_ready),
    .resp_rdata(rd0), .resp_error(err0));

  data_memory_responder #(.WORDSIZE(64), .DEPTH(512), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rdy1),
    .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3),
    .req_wdata(req_wdata), .resp_valid(rv1), .resp_ready(resp_ready),
    .resp_rdata(rd1), .resp_error(err1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Scoreboard monitor: a response is consumed on the edge after valid&ready
  always @(negedge clk) begin
    if (rst_n && rv_m && resp_ready) begin
      if (exp_q.size() == 0) chk("spurious_resp", 64'd1, 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("rdata", rd_m, mon_e[63:0]);
        chk("error", 64'(err_m), 64'(mon_e[64]));
      end
    end
  end

  // One transaction: issue, check latency, optional backpressure, check return to idle
  task automatic send(input logic w, input logic [63:0] a, input logic [2:0] f,
                      input logic [63:0] d, input logic [63:0] er, input logic ee,
                      input int hold);
    int  acc, k;
    bit  ok;
    exp_q.push_back({ee, er});
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_funct3 = f; req_wdata = d;
    resp_ready = (hold == 0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy_m) begin ok = 1'b1; break; end
    end
    if (!ok) begin chk("accept_timeout", 64'd0, 64'd1); req_valid = 1'b0; return; end
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rv_m) begin ok = 1'b1; break; end
    end
    if (!ok) begin chk("resp_timeout", 64'd0, 64'd1); return; end
    chk("latency", 64'(cyc - acc), sel ? 64'd1 : 64'd2);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rv_m), 64'd1);
      chk("bp_rdata", rd_m, exp_q[0][63:0]);
      chk("bp_error", 64'(err_m), 64'(exp_q[0][64]));
      chk("bp_ready", 64'(rdy_m), 64'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
    end
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      k++;
      if (!rv_m) break;
    end
    chk("idle_next", 64'(k), 64'd1);
    chk("ready_after", 64'(rdy_m), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_funct3 = '0; req_wdata = '0; resp_ready = 1'b1; sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(rdy_m), 64'd0);
    chk("rst_valid", 64'(rv_m), 64'd0);
    chk("rst_rdata", rd_m, 64'd0);
    chk("rst_error", 64'(err_m), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    send(1, 64'h10, 3'b011, 64'h8877665544332211, 64'h0, 0, 0);
    send(0, 64'h10, 3'b011, 64'h0, 64'h8877665544332211, 0, 0);
    send(1, 64'h13, 3'b000, 64'hAB, 64'h0, 0, 0);
    send(0, 64'h10, 3'b011, 64'h0, 64'h88776655AB332211, 0, 0);
    send(0, 64'h13, 3'b000, 64'h0, 64'hFFFFFFFFFFFFFFAB, 0, 0);
    send(0, 64'h13, 3'b100, 64'h0, 64'h00000000000000AB, 0, 0);
    send(0, 64'h14, 3'b010, 64'h0, 64'hFFFFFFFF88776655, 0, 0);
    send(0, 64'h11, 3'b001, 64'h0, 64'h0, 1, 0);
    send(1, 64'h1004, 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1, 0);
    send(1, 64'h1010, 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1, 0);
    send(0, 64'h10, 3'b011, 64'h0, 64'h88776655AB332211, 0, 0);
    send(0, 64'h12, 3'b101, 64'h0, 64'h000000000000AB33, 0, 0);
    send(0, 64'h12, 3'b001, 64'h0, 64'hFFFFFFFFFFFFAB33, 0, 0);
    send(0, 64'h14, 3'b110, 64'h0, 64'h0000000088776655, 0, 0);
    send(1, 64'h16, 3'b001, 64'h1234, 64'h0, 0, 0);
    send(0, 64'h1000, 3'b011, 64'h0, 64'h0, 1, 0);
    send(1, 64'h10, 3'b100, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1, 0);
    send(0, 64'h10, 3'b111, 64'h0, 64'h0, 1, 0);
    send(0, 64'h12, 3'b010, 64'h0, 64'h0, 1, 0);
    send(1, 64'h14, 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1, 0);
    send(0, 64'h10, 3'b011, 64'h0, 64'h12346655AB332211, 0, 5);

    // Reset during BUSY abandons a pending store
    send(1, 64'h20, 3'b011, 64'hDEADBEEFCAFEF00D, 64'h0, 0, 0);
    send(0, 64'h20, 3'b011, 64'h0, 64'hDEADBEEFCAFEF00D, 0, 0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_funct3 = 3'b011;
    req_wdata = 64'h1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_ready", 64'(rdy_m), 64'd0);
    chk("async_valid", 64'(rv_m), 64'd0);
    chk("async_rdata", rd_m, 64'd0);
    chk("async_error", 64'(err_m), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    send(0, 64'h20, 3'b011, 64'h0, 64'hDEADBEEFCAFEF00D, 0, 0);

    // LATENCY=1 instance
    @(posedge clk); #1 sel = 1'b1;
    send(1, 64'h30, 3'b011, 64'h0123456789ABCDEF, 64'h0, 0, 0);
    send(0, 64'h30, 3'b011, 64'h0, 64'h0123456789ABCDEF, 0, 0);
    send(0, 64'h31, 3'b001, 64'h0, 64'h0, 1, 0);
    send(0, 64'h37, 3'b000, 64'h0, 64'h0000000000000001, 0, 0);

    // Back-to-back: req_valid held high, one transaction every 3 cycles
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 64'hFFFFFFFF89ABCDEF});
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h30; req_funct3 = 3'b010;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (rdy_m) begin ok = 1'b1; break; end
      end
      if (!ok) begin chk("b2b_timeout", 64'd0, 64'd1); break; end
      @(posedge clk); #1;
      acc_t[i] = cyc;
      if (i == 3) req_valid = 1'b0;
      if (i > 0) chk("b2b_period", 64'(acc_t[i] - acc_t[i-1]), 64'd3);
    end
    req_valid = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder side of the processor's data-memory interface.
- The datapath/control unit issues load/store requests. This block accepts them over a valid/ready handshake, models a fixed access latency, and returns load data or a completion on a response channel.
- It implements RV64 byte/half/word/double accesses with sign/zero extension and reports misaligned or out-of-range accesses.
- It replaces the single-cycle `dm_write_en` path in the multicycle processor.

Parameters:
- WORDSIZE, 64, data and address width.
- DEPTH, 512, number of 64-bit memory words; must be a power of two.
- LATENCY, 2, cycles spent in BUSY before a response; minimum 1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  WORDSIZE  byte address.
- req_funct3  input  3  RISC-V funct3 giving access size and signedness.
- req_wdata  input  WORDSIZE  store data; the low bytes are used according to size.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  WORDSIZE  load result, extended; 0 for stores and errors.
- resp_error  output  1  access was faulted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - resp_valid=0, resp_rdata=0, resp_error=0, req_ready=0 while rst_n is low.
  - The counter and captured request clear.
  - Memory contents are not reset.
  - Reset mid-BUSY abandons the access; a pending store is not written.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture write/addr/funct3/wdata, load counter with LATENCY-1, go to BUSY.
  - BUSY: req_ready=0. Decrement counter each cycle. When counter==0, perform the access and go to RESP.
    - The access is a memory write for stores; for loads, resp_rdata/resp_error are registered.
    - Total accept-to-resp_valid latency is exactly LATENCY cycles.
  - RESP: resp_valid=1 and outputs are held stable until resp_ready=1.
    - On that cycle, go to IDLE and clear resp_valid.
    - A new request is accepted no earlier than the following cycle; there is no overlap.
- Access sizes (funct3):
  - Load: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu. Sign-extend lb/lh/lw; zero-extend the others.
  - Store: 000 sb, 001 sh, 010 sw, 011 sd. funct3[2]=1 on a store is an error.
  - Load funct3 111 is an error.
- Addressing:
  - Little-endian.
  - Word index = req_addr[3 +: log2(DEPTH)]; byte offset = req_addr[2:0].
  - Stores modify only the addressed bytes; other bytes of the word are preserved (read-modify-write within one cycle).
- Errors (resp_error=1, resp_rdata=0, no memory modification):
  - Misalignment: offset not a multiple of access size (h: addr[0]; w: addr[1:0]; d: addr[2:0] nonzero).
  - Out of range: any req_addr bit at or above 3+log2(DEPTH) set.
  - Illegal funct3 as listed above.
- req_wdata and req_addr changing after acceptance have no effect.
- resp_valid and resp_error never toggle while in RESP with resp_ready=0.

Test Plan:
- Reset, then sd addr 0x10 data 0x8877665544332211, then ld 0x10.
  - Each response arrives exactly 2 cycles after acceptance.
  - ld returns 0x8877665544332211 with resp_error=0.
- After the above: sb addr 0x13 data 0xAB, then ld 0x10 returns 0x88776655AB332211. Then:
  - lb 0x13 returns 0xFFFFFFFFFFFFFFAB.
  - lbu 0x13 returns 0x00000000000000AB.
  - lw 0x14 returns 0xFFFFFFFF88776655.
- Misalignment and range:
  - lh 0x11 gives resp_error=1, rdata=0.
  - sd 0x1004 with DEPTH=512 gives an error.
  - A following ld 0x10 still returns the prior value, proving neither faulted request modified memory.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP.
  - resp_valid/resp_rdata stay stable; req_ready=0 throughout.
  - Raise resp_ready: IDLE next cycle, req_ready=1.
- Reset mid-operation: sd 0x20 data 0x1, then assert rst_n=0 during BUSY.
  - Outputs go to 0 immediately (asynchronously).
  - After release, ld 0x20 returns the pre-existing contents, not 0x1.
- LATENCY=1 instance: resp_valid asserts one cycle after acceptance. Back-to-back requests with resp_ready held at 1 complete at one transaction every 3 cycles.
